miner_host_if: RTL
==================

Name: miner_host_if

Overview:
Host-side command/status front end for the mining controller. It accepts host register writes for the 256-bit target and the 608-bit block header (nonce excluded), and presents them as stable buses. It drives the newTarget/newMsg request levels, consumes the controller's acknowledge and result strobes, and exposes sticky status, the winning nonce and an interrupt.

Parameters:
TGT_WORDS, 8, 32-bit words of target (256 bits)
MSG_WORDS, 19, 32-bit words of header excluding nonce (608 bits)
ADDR_W, 5, host address width

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
wr_en  in  1  host write strobe
wr_addr  in  ADDR_W  host write word address
wr_data  in  32  host write data
rd_en  in  1  host read strobe
rd_addr  in  ADDR_W  host read word address
rd_data  out  32  read data, registered
newTarget  out  1  target request level to controller
newMsg  out  1  message request level to controller
target_out  out  256  active target, stable between commits
msg_out  out  608  active header, stable between commits
loadTarget  in  1  controller target acknowledge
loadMsg  in  1  controller message acknowledge (error-recovery path)
beginSHA  in  1  controller start strobe (message acknowledge from idle)
btcFound  in  1  controller success strobe
error  in  1  controller nonce-overflow level
nonce_in  in  32  current nonce from datapath
irq  out  1  found | err sticky

Behaviour:
- Reset: all staging/active regs, pending bits, mining, sticky bits, found_nonce, rd_data = 0. newTarget, newMsg and irq are 0.
- Address map (word), word 0 = bits 31:0:
  - 0-7: target staging, R/W.
  - 8-26: header staging, R/W.
  - 27: CMD, write-only. bit0 = commit target, bit1 = commit msg.
  - 28: STATUS. Read layout: {26'b0, reject, err, found, mining, msg_pend, tgt_pend}. Write 1 to bits 3-5 clears them (W1C).
  - 29: FOUND_NONCE, read-only.
  - Unmapped: reads return 0, writes are ignored.
- Reads: rd_data updates on the clock edge after rd_en (1-cycle latency) and holds otherwise. A same-cycle write+read to one address returns the old value.
- Commit, on a CMD write:
  - If mining = 0: copy the selected staging into the active registers on that edge, and set the matching pending bit.
  - If mining = 1: the commit is ignored and reject is set.
  - Re-commit while pending (not mining) recopies the active registers; the pending bit stays 1.
- newTarget = tgt_pend and newMsg = msg_pend (levels).
- Pending clear: tgt_pend clears on the edge where loadTarget = 1. msg_pend clears on the edge where loadMsg | beginSHA = 1 while msg_pend = 1.
- Commit with both bits in one write: both pend. The controller services target first; msg stays asserted until its acknowledge.
- Mining:
  - Set on the msg acknowledge edge.
  - Cleared on btcFound, or on the rising edge of error.
  - beginSHA with msg_pend = 0 (nonce retry) does not affect pending state.
- btcFound: capture nonce_in into FOUND_NONCE, set found, clear mining.
- error rising edge: set err, clear mining.
- Sticky set vs W1C in the same cycle: set wins.
- irq = found | err, registered.
- Reset asserted mid-operation: immediate return to reset values. The controller sees newTarget/newMsg drop asynchronously.

Decomposition:
- Package miner_pkg: address constants (ADDR_TGT0, ADDR_MSG0, ADDR_CMD, ADDR_STATUS, ADDR_NONCE), status bit indices, and CMD bit indices.
- One natural sub-module, miner_req_track: a pending/ack/sticky bookkeeping FSM (pending bits, mining, sticky flags, irq).
- The register file stays in the top.

Test Plan:
- Write target words 0-7 = 0x0000FFFF…, write CMD = 1 → target_out updates next edge, newTarget = 1; pulse loadTarget → newTarget = 0, STATUS reads 0x00.
- Write header, CMD = 2, then assert beginSHA one cycle → newMsg = 0 and STATUS = 0x04 (mining). Then a CMD = 1 write → target_out unchanged and STATUS = 0x24 (reject set).
- While mining, nonce_in = 0x1234ABCD with btcFound pulse → FOUND_NONCE = 0x1234ABCD, STATUS = 0x08, irq = 1 the next cycle. W1C 0x08 → STATUS = 0x00, irq = 0.
- Assert error while mining → STATUS = 0x10. CMD = 2 accepted; loadMsg acknowledge → msg_pend clears, mining = 1 (STATUS = 0x14).
- CMD = 3 in one write → newTarget = newMsg = 1. loadTarget → only newMsg remains. beginSHA → newMsg = 0.
- btcFound in the same cycle as a W1C 0x08 → found stays 1. Assert rst mid-mining → all outputs 0 immediately, rd_data = 0.

Source files
------------

// File: rtl/miner_pkg.sv
// Shared constants and types for the miner host interface.
package miner_pkg;

  // Host word address map
  localparam int unsigned ADDR_TGT0   = 0;
  localparam int unsigned ADDR_MSG0   = 8;
  localparam int unsigned ADDR_CMD    = 27;
  localparam int unsigned ADDR_STATUS = 28;
  localparam int unsigned ADDR_NONCE  = 29;

  // STATUS register bit positions
  localparam int unsigned ST_TGT_PEND = 0;
  localparam int unsigned ST_MSG_PEND = 1;
  localparam int unsigned ST_MINING   = 2;
  localparam int unsigned ST_FOUND    = 3;
  localparam int unsigned ST_ERR      = 4;
  localparam int unsigned ST_REJECT   = 5;

  // CMD register bit positions
  localparam int unsigned CMD_TGT = 0;
  localparam int unsigned CMD_MSG = 1;

  typedef enum logic {
    StIdle,
    StMining
  } mine_state_t;

  // Field order matches the STATUS read layout (tgt_pend is bit 0)
  typedef struct packed {
    logic reject;
    logic err;
    logic found;
    logic mining;
    logic msg_pend;
    logic tgt_pend;
  } status_t;

  function automatic logic [31:0] status_word(status_t s);
    return {26'b0, s};
  endfunction

endpackage

// File: rtl/miner_req_track.sv
// Request/acknowledge bookkeeping: pending bits, mining phase, sticky flags and irq.
module miner_req_track
  import miner_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic    cmd_wr,
  input  logic    cmd_tgt,
  input  logic    cmd_msg,
  input  logic    clr_found,
  input  logic    clr_err,
  input  logic    clr_reject,
  input  logic    loadTarget,
  input  logic    loadMsg,
  input  logic    beginSHA,
  input  logic    btcFound,
  input  logic    error,
  output logic    commit_ok,
  output status_t status,
  output logic    irq
);

  mine_state_t state;
  logic tgt_pend, msg_pend, found, err, reject, error_prev;
  logic mining, msg_ack, err_rise, reject_set;
  logic found_d, err_d, reject_d;

  // Event decode and sticky next-state; a set in the same cycle beats a W1C
  always_comb begin
    mining     = (state == StMining);
    msg_ack    = msg_pend & (loadMsg | beginSHA);
    err_rise   = error & ~error_prev;
    commit_ok  = cmd_wr & ~mining;
    reject_set = cmd_wr & mining & (cmd_tgt | cmd_msg);
    found_d    = btcFound   | (found  & ~clr_found);
    err_d      = err_rise   | (err    & ~clr_err);
    reject_d   = reject_set | (reject & ~clr_reject);
  end

  // Pending bits, mining phase, sticky flags and registered irq
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= StIdle;
      tgt_pend   <= 1'b0;
      msg_pend   <= 1'b0;
      found      <= 1'b0;
      err        <= 1'b0;
      reject     <= 1'b0;
      error_prev <= 1'b0;
      irq        <= 1'b0;
    end else begin
      error_prev <= error;

      // A fresh commit re-arms the request even if an ack lands the same cycle
      if (commit_ok && cmd_tgt) tgt_pend <= 1'b1;
      else if (loadTarget)      tgt_pend <= 1'b0;

      if (commit_ok && cmd_msg) msg_pend <= 1'b1;
      else if (msg_ack)         msg_pend <= 1'b0;

      unique case (state)
        StIdle:   if (msg_ack) state <= StMining;
        StMining: if (btcFound || err_rise) state <= StIdle;
        default:  state <= StIdle;
      endcase

      found  <= found_d;
      err    <= err_d;
      reject <= reject_d;
      irq    <= found_d | err_d;
    end
  end

  always_comb begin
    status          = '0;
    status.tgt_pend = tgt_pend;
    status.msg_pend = msg_pend;
    status.mining   = mining;
    status.found    = found;
    status.err      = err;
    status.reject   = reject;
  end

endmodule

// File: rtl/miner_host_if.sv
// Host register front end for the mining controller: staging/active target and
// header, command/status registers, winning nonce capture and registered reads.
module miner_host_if
  import miner_pkg::*;
#(
  parameter int unsigned TGT_WORDS = 8,
  parameter int unsigned MSG_WORDS = 19,
  parameter int unsigned ADDR_W    = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [ADDR_W-1:0]      wr_addr,
  input  logic [31:0]            wr_data,
  input  logic                   rd_en,
  input  logic [ADDR_W-1:0]      rd_addr,
  output logic [31:0]            rd_data,
  output logic                   newTarget,
  output logic                   newMsg,
  output logic [TGT_WORDS*32-1:0] target_out,
  output logic [MSG_WORDS*32-1:0] msg_out,
  input  logic                   loadTarget,
  input  logic                   loadMsg,
  input  logic                   beginSHA,
  input  logic                   btcFound,
  input  logic                   error,
  input  logic [31:0]            nonce_in,
  output logic                   irq
);

  logic [TGT_WORDS-1:0][31:0] tgt_stage;
  logic [MSG_WORDS-1:0][31:0] msg_stage;
  logic [31:0]                found_nonce;
  logic [31:0]                wa, ra, rd_next;
  logic                       cmd_wr, status_wr, commit_ok;
  status_t                    status;

  assign wa        = 32'(wr_addr);
  assign ra        = 32'(rd_addr);
  assign cmd_wr    = wr_en && (wa == ADDR_CMD);
  assign status_wr = wr_en && (wa == ADDR_STATUS);

  miner_req_track u_req_track (
    .clk        (clk),
    .rst        (rst),
    .cmd_wr     (cmd_wr),
    .cmd_tgt    (wr_data[CMD_TGT]),
    .cmd_msg    (wr_data[CMD_MSG]),
    .clr_found  (status_wr & wr_data[ST_FOUND]),
    .clr_err    (status_wr & wr_data[ST_ERR]),
    .clr_reject (status_wr & wr_data[ST_REJECT]),
    .loadTarget (loadTarget),
    .loadMsg    (loadMsg),
    .beginSHA   (beginSHA),
    .btcFound   (btcFound),
    .error      (error),
    .commit_ok  (commit_ok),
    .status     (status),
    .irq        (irq)
  );

  assign newTarget = status.tgt_pend;
  assign newMsg    = status.msg_pend;

  // Host writes into the staging words
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tgt_stage <= '0;
      msg_stage <= '0;
    end else if (wr_en) begin
      for (int unsigned i = 0; i < TGT_WORDS; i++) begin
        if (wa == ADDR_TGT0 + i) tgt_stage[i] <= wr_data;
      end
      for (int unsigned i = 0; i < MSG_WORDS; i++) begin
        if (wa == ADDR_MSG0 + i) msg_stage[i] <= wr_data;
      end
    end
  end

  // Accepted commits copy staging into the active buses; rejected ones leave them alone
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      target_out <= '0;
      msg_out    <= '0;
    end else begin
      if (commit_ok && wr_data[CMD_TGT]) target_out <= tgt_stage;
      if (commit_ok && wr_data[CMD_MSG]) msg_out    <= msg_stage;
    end
  end

  // Capture the winning nonce on the success strobe
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      found_nonce <= '0;
    end else if (btcFound) begin
      found_nonce <= nonce_in;
    end
  end

  // Read mux; unmapped and write-only addresses read as zero
  always_comb begin
    rd_next = '0;
    for (int unsigned i = 0; i < TGT_WORDS; i++) begin
      if (ra == ADDR_TGT0 + i) rd_next = tgt_stage[i];
    end
    for (int unsigned i = 0; i < MSG_WORDS; i++) begin
      if (ra == ADDR_MSG0 + i) rd_next = msg_stage[i];
    end
    if (ra == ADDR_STATUS) rd_next = status_word(status);
    if (ra == ADDR_NONCE)  rd_next = found_nonce;
  end

  // Registered read data, held between reads
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= rd_next;
    end
  end

endmodule
